// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx
//   Stereo I2S transmitter. A one-deep holding register takes {left, right}
//   sample pairs from a valid/ready producer; once per frame, on the bit-clock
//   falling edge that moves the slot counter from 0 to 1, the pair is copied
//   into a 2*SAMPLE_W shift register and shifted out MSB first. The I2S
//   one-bit delay after the LRCK edge therefore falls out naturally: slot 0
//   still carries the previous frame's right-channel LSB.
//
// Ports
//   clk, reset      system clock (>= 4x bclk_in), synchronous active-high reset
//   bclk_in         divided bit clock, asynchronous to clk
//   sample_l/_r     two's-complement channel samples
//   sample_valid    producer offers a pair
//   sample_ready    holding register empty
//   underrun_clr    clears the sticky underrun flag
//   i2s_bclk        re-timed bit clock
//   i2s_lrck        word select (0 = left, 1 = right)
//   i2s_data        serial data, MSB first
//   underrun        sticky: a frame was loaded with no pending pair
module i2s_audio_tx #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk_in,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_data,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int SLOT_W  = $clog2(FRAME_W);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SAMPLE_W);

  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               lrck_q, lrck_d;
  logic               data_q, data_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic               full_q, full_d;
  logic               underrun_q, underrun_d;

  logic fall_stb;
  logic load;
  logic accept;

  always_comb begin
    // Two flops resynchronise bclk_in; the third gives a delayed copy so a
    // falling edge is seen as s3=1, s2=0 and i2s_bclk (= s3) drops on the
    // same clk edge that lrck and data update.
    s1_d = bclk_in;
    s2_d = s1_q;
    s3_d = s2_q;

    fall_stb = s3_q & ~s2_q;
    load     = fall_stb & (slot_q == '0);
    accept   = sample_valid & ~full_q;

    slot_d     = slot_q;
    lrck_d     = lrck_q;
    data_d     = data_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    full_d     = full_q;
    underrun_d = underrun_q;

    if (fall_stb) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      lrck_d = (slot_d >= SLOT_RIGHT);
      if (load) begin
        // The load sees only the pre-cycle holding contents; a pair handed
        // over in this very cycle waits for the next frame.
        frame_d = full_q ? hold_q : '0;
      end else begin
        frame_d = frame_q << 1;
      end
      data_d = frame_d[FRAME_W-1];
    end

    if (accept) begin
      hold_d = {sample_l, sample_r};
    end

    // Acceptance can coincide with a load only when the register was empty,
    // so "accept wins" never loses a pair.
    if (accept) begin
      full_d = 1'b1;
    end else if (load) begin
      full_d = 1'b0;
    end

    if (load && !full_q) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      slot_q     <= '0;
      lrck_q     <= 1'b0;
      data_q     <= 1'b0;
      frame_q    <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      slot_q     <= slot_d;
      lrck_q     <= lrck_d;
      data_q     <= data_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_ready = ~full_q;
  assign i2s_bclk     = s3_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_data     = data_q;
  assign underrun     = underrun_q;

endmodule

// File: doc/i2s_audio_tx.md
I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 Parameter SAMPLE_W, default 16, SHALL set the per-channel sample width; each frame SHALL have 2*SAMPLE_W bit slots.
REQ-002 clk  in  1  SHALL be the single system clock, with frequency at least 4x that of bclk_in.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 bclk_in  in  1  SHALL be the divided audio bit clock from the clock divider; it is asynchronous to clk.
REQ-005 sample_l  in  SAMPLE_W  SHALL be the left-channel sample, two's complement.
REQ-006 sample_r  in  SAMPLE_W  SHALL be the right-channel sample, two's complement.
REQ-007 sample_valid  in  1  SHALL indicate that the producer offers a stereo pair.
REQ-008 sample_ready  out  1  SHALL indicate that the holding register is empty.
REQ-009 underrun_clr  in  1  SHALL clear the underrun flag.
REQ-010 i2s_bclk  out  1  SHALL be the re-timed bit clock.
REQ-011 i2s_lrck  out  1  SHALL be word select: 0 for left, 1 for right.
REQ-012 i2s_data  out  1  SHALL be serial data, MSB first.
REQ-013 underrun  out  1  SHALL be a sticky flag marking a frame loaded with no pending sample.

Function
REQ-014 Synchronisation SHALL work as follows:
- bclk_in passes through two flops (s1, s2), then a third flop s3.
- i2s_bclk = s3.
- fall_stb = s3 & ~s2.
- rise_stb is unused.
REQ-015 A slot counter SHALL behave as follows:
- Range 0..2*SAMPLE_W-1.
- Increments on each fall_stb.
- Wraps from 2*SAMPLE_W-1 to 0.
- Holds between strobes.
REQ-016 i2s_lrck SHALL be registered on fall_stb as 0 when the new slot is less than SAMPLE_W, else 1; it changes in the same clk cycle as i2s_bclk falls.
REQ-017 Frame load:
- Occurs on the fall_stb where the slot goes from 0 to 1.
- The 2*SAMPLE_W frame shift register loads {L,R} from the holding register.
- i2s_data takes the frame MSB in that same cycle, giving the one-BCLK I2S delay after the LRCK edge.
REQ-018 On every other fall_stb, the frame register SHALL shift left by one bit and i2s_data SHALL take the new MSB; slot 0 therefore carries the previous right LSB.
REQ-019 The holding register SHALL accept {sample_l, sample_r} when sample_valid & sample_ready, and SHALL become full.
REQ-020 sample_ready SHALL equal ~full (combinational).
REQ-021 A frame load from a full holding register SHALL clear full in the next cycle.
REQ-022 A frame load while the holding register is empty SHALL:
- load all-zeros;
- set underrun;
- leave any handshake in the same cycle pending for the next frame, with no bypass.
REQ-023 A handshake and a frame load in the same cycle SHALL resolve as follows:
- The load uses the pre-cycle holding contents.
- full ends the cycle as 1 if accepted, else per REQ-021.
REQ-024 underrun SHALL clear on underrun_clr; if a set and a clear occur in the same cycle, set SHALL win.
REQ-025 A sample_valid deasserted without a handshake SHALL be ignored; samples SHALL never be dropped or duplicated.
REQ-026 bclk_in stopping SHALL freeze the slot counter, lrck and data, with the handshake still operating.

Reset
REQ-027 On reset:
- s1, s2, s3, the slot counter, the frame register, i2s_lrck, i2s_data, underrun and full SHALL all be 0.
- sample_ready SHALL be 1 and i2s_bclk SHALL be 0.
REQ-028 A reset asserted mid-frame SHALL take effect at the next clk edge. After release, the first load SHALL occur at the first 0->1 slot transition.
REQ-029 A reset SHALL discard any pending holding-register sample without setting underrun.

Verification
REQ-030 SAMPLE_W=16, clk=8x bclk_in; accept L=16'hA5C3, R=16'h0F01 before slot 1 -> i2s_data over slots 1..31,0 = A5C3 then 0F01 MSB first; lrck 0 on slots 0-15, 1 on slots 16-31.
REQ-031 No sample offered for a full frame -> 32 zero bits, underrun=1 stays set until underrun_clr pulse, then 0.
REQ-032 Assert sample_valid in the exact cycle of a frame load while empty -> zeros transmitted and underrun=1; the accepted pair is transmitted in the next frame; sample_ready=0 until that frame's load.
REQ-033 Back-to-back valid with a full holding register -> sample_ready=0 and no acceptance; acceptance occurs one cycle after the frame load; the sequence 1,2,3 arrives in order with none lost.
REQ-034 Reset pulse at slot 20 -> all outputs 0 and sample_ready=1 next cycle; after release, the counter restarts at the first fall_stb and the first load occurs at the 0->1 transition.
REQ-035 Stop bclk_in for 100 clk mid-frame -> lrck, data and counter unchanged; on resume the frame continues from the same slot.
